sync_fifo_flex: RTL and testbench

//  Single-clock FIFO that buffers pixel or line data between stages of the image pipeline (Sobel, filters).

---
 rtl/sync_fifo_flex_pkg.sv | 30 +++
 rtl/sync_fifo_flex_if.sv | 30 +++
 rtl/sync_fifo_flex_ram.sv | 24 ++
 rtl/sync_fifo_flex.sv | 97 +++++++++
 tb/tb_sync_fifo_flex.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_flex_pkg.sv
// img_fifo_pkg: sizing helpers and the status bundle shared by the FIFO, its RAM and its interface.
package img_fifo_pkg;

   function automatic int clog2(input int n);
      int w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return clog2(depth);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                           almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};

endpackage

// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: control, data and status bundle of the flexible FIFO.
interface sync_fifo_flex_if import img_fifo_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1024
);
   localparam int CNT_W = cnt_width(DEPTH);
   logic                  clr;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_W-1:0]      data_count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, wr_en, din, rd_en,
      input  dout, dout_valid, full, empty, almost_full, almost_empty, data_count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, din, rd_en,
      output dout, dout_valid, full, empty, almost_full, almost_empty, data_count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flex_ram.sv
// sdp_ram: simple dual-port RAM, synchronous write, registered read with enable (BRAM-friendly).
module sdp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: any-depth single-clock FIFO with exact count, programmable thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; the RAM read register then serves as the output stage.
module sync_fifo_flex import img_fifo_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1024,
   parameter int AF_LEVEL   = 1020,
   parameter int AE_LEVEL   = 4
) (
   input logic           clk,
   input logic           rst_n,
   sync_fifo_flex_if.slave f
);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = ptr_width(DEPTH);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   fifo_status_t          st_q, st_d;
   logic                  ld_q, ld_d, dv_q, dv_d;
   logic                  wr_acc, rd_acc, re;
   logic [DATA_WIDTH-1:0] ram_q;

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_acc = f.wr_en & ~st_q.full;
      rd_acc = f.rd_en & ~st_q.empty;
      count_d = (wr_acc & ~rd_acc) ? count_q + CNT_W'(1) :
                (rd_acc & ~wr_acc) ? count_q - CNT_W'(1) : count_q;
`ifdef SYNC_FIFO_FWFT_EN
      // fetch whenever RAM holds a word and the output stage is free or being popped
      re = (count_q != CNT_W'(dv_q)) & (~dv_q | rd_acc);
      dv_d = re | (dv_q & ~rd_acc);
      st_d.empty = ~dv_d;
`else
      re = rd_acc;
      dv_d = rd_acc;
      st_d.empty = (count_d == '0);
`endif
      st_d.full = (count_d == CNT_W'(DEPTH));
      st_d.almost_full = (count_d >= CNT_W'(AF_LEVEL));
      st_d.almost_empty = (count_d <= CNT_W'(AE_LEVEL));
      st_d.overflow = st_q.overflow | (f.wr_en & st_q.full);
      st_d.underflow = st_q.underflow | (f.rd_en & st_q.empty);
      ld_d = ld_q | re;
      wr_ptr_d = wr_acc ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = re ? inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         st_q     <= STATUS_RST;
         ld_q     <= 1'b0;
         dv_q     <= 1'b0;
      end else if (f.clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         st_q     <= STATUS_RST;
         ld_q     <= 1'b0;
         dv_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         st_q     <= st_d;
         ld_q     <= ld_d;
         dv_q     <= dv_d;
      end
   end

   sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(PTR_W)) u_ram (
      .clk     (clk),
      .we_i    (wr_acc & ~f.clr),
      .waddr_i (wr_ptr_q),
      .wdata_i (f.din),
      .re_i    (re & ~f.clr),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_q)
   );

   // the RAM read register is not reset, so dout reads zero until the first word is loaded
   assign f.dout         = ld_q ? ram_q : '0;
   assign f.dout_valid   = dv_q;
   assign f.full         = st_q.full;
   assign f.empty        = st_q.empty;
   assign f.almost_full  = st_q.almost_full;
   assign f.almost_empty = st_q.almost_empty;
   assign f.overflow     = st_q.overflow;
   assign f.underflow    = st_q.underflow;
   assign f.data_count   = count_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed checks of sync_fifo_flex at DEPTH=8 and DEPTH=6, in either FWFT setting.
module tb_sync_fifo_flex;
`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(8)) a ();
   sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(6)) b ();

   sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
      .clk(clk), .rst_n(rst_n), .f(a.slave));
   sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1)) u_b (
      .clk(clk), .rst_n(rst_n), .f(b.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic pop(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
      check({tag, "_dout"}, a.dout, exp);
      check({tag, "_dv"}, a.dout_valid, 1);
`endif
      a.rd_en = 1'b1;
      step();
      a.rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      check({tag, "_dout"}, a.dout, exp);
      check({tag, "_dv"}, a.dout_valid, 1);
`endif
   endtask

   task automatic push(input logic [7:0] d);
      a.wr_en = 1'b1;
      a.din = d;
      step();
      a.wr_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] seq [13];
      int rx;
      {a.clr, a.wr_en, a.rd_en, a.din} = '0;
      {b.clr, b.wr_en, b.rd_en, b.din} = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      check("rst_empty", a.empty, 1);
      check("rst_ae", a.almost_empty, 1);
      check("rst_full", a.full, 0);
      check("rst_af", a.almost_full, 0);
      check("rst_cnt", a.data_count, 0);
      check("rst_dout", a.dout, 0);
      check("rst_dv", a.dout_valid, 0);
      check("rst_ovf", a.overflow, 0);
      check("rst_b_empty", b.empty, 1);

      // fill to full, then one rejected write
      for (int i = 1; i <= 8; i++) begin
         push(8'(i));
         check("fill_cnt", a.data_count, i);
         check("fill_af", a.almost_full, i >= 6);
         check("fill_ae", a.almost_empty, i <= 2);
         check("fill_full", a.full, i == 8);
      end
      push(8'hFF);
      check("ovf_set", a.overflow, 1);
      check("ovf_cnt", a.data_count, 8);

      for (int i = 1; i <= 8; i++) begin
         pop("drain", 8'(i));
         check("drain_cnt", a.data_count, 8 - i);
      end
      check("drain_empty", a.empty, 1);
      check("drain_unf0", a.underflow, 0);
      a.rd_en = 1'b1;
      step();
      a.rd_en = 1'b0;
      check("unf_set", a.underflow, 1);
      check("unf_dout", a.dout, 8'h08);
      check("unf_dv", a.dout_valid, 0);

      // write-to-readable latency
      push(8'hA5);
      check("lat_empty1", a.empty, FWFT);
      check("lat_cnt", a.data_count, 1);
      step();
      check("lat_empty2", a.empty, 0);
      pop("lat", 8'hA5);
      check("lat_empty3", a.empty, 1);

      // steady state at count 3 with simultaneous write and read
      seq = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
      for (int i = 0; i < 3; i++) push(seq[i]);
      for (int k = 0; k < 10; k++) begin
         a.wr_en = 1'b1;
         a.rd_en = 1'b1;
         a.din = seq[k + 3];
         step();
         check("sim_cnt", a.data_count, 3);
         check("sim_dout", a.dout, FWFT ? seq[k + 1] : seq[k]);
      end
      a.wr_en = 1'b0;
      a.rd_en = 1'b0;
      for (int i = 10; i < 13; i++) pop("sim_tail", seq[i]);
      check("sim_empty", a.empty, 1);

      // write+read while full, then while empty
      for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
      a.wr_en = 1'b1;
      a.rd_en = 1'b1;
      a.din = 8'h38;
      step();
      a.wr_en = 1'b0;
      a.rd_en = 1'b0;
      check("fullrw_cnt", a.data_count, 7);
      check("fullrw_ovf", a.overflow, 1);
      for (int i = 1; i < 8; i++) pop("fullrw", 8'h30 + 8'(i));
      check("fullrw_empty", a.empty, 1);
      a.clr = 1'b1;
      step();
      a.clr = 1'b0;
      a.wr_en = 1'b1;
      a.rd_en = 1'b1;
      a.din = 8'h40;
      step();
      a.wr_en = 1'b0;
      a.rd_en = 1'b0;
      check("emptyrw_cnt", a.data_count, 1);
      check("emptyrw_unf", a.underflow, 1);

      // clr mid-operation, concurrent with a write
      for (int i = 1; i <= 4; i++) push(8'h40 + 8'(i));
      check("pre_clr_cnt", a.data_count, 5);
      a.clr = 1'b1;
      a.wr_en = 1'b1;
      a.din = 8'h66;
      step();
      a.clr = 1'b0;
      a.wr_en = 1'b0;
      check("clr_cnt", a.data_count, 0);
      check("clr_empty", a.empty, 1);
      check("clr_ae", a.almost_empty, 1);
      check("clr_unf", a.underflow, 0);
      check("clr_dout", a.dout, 0);
      check("clr_dv", a.dout_valid, 0);

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
      a.wr_en = 1'b1;
      a.rd_en = 1'b1;
      a.din = 8'h53;
      step();
      check("burst_dv", a.dout_valid, 1);
      check("burst_dout", a.dout, FWFT ? 8'h51 : 8'h50);
      rst_n = 1'b0;
      #2;
      check("arst_cnt", a.data_count, 0);
      check("arst_empty", a.empty, 1);
      check("arst_dout", a.dout, 0);
      check("arst_dv", a.dout_valid, 0);
      check("arst_full", a.full, 0);
      a.wr_en = 1'b0;
      a.rd_en = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // ramp through DEPTH=6 across pointer wrap
      rx = 0;
      for (int c = 0; c < 40 && rx < 20; c++) begin
         b.wr_en = (c < 20);
         b.din = 8'(c);
         b.rd_en = (c >= 3) && !b.empty;
`ifdef SYNC_FIFO_FWFT_EN
         if (b.rd_en) begin
            check("wrap_dout", b.dout, rx);
            rx++;
         end
`endif
         step();
`ifndef SYNC_FIFO_FWFT_EN
         if (b.dout_valid) begin
            check("wrap_dout", b.dout, rx);
            rx++;
         end
`endif
      end
      b.wr_en = 1'b0;
      b.rd_en = 1'b0;
      check("wrap_count", rx, 20);
      check("wrap_cnt", b.data_count, 0);
      check("wrap_ovf", b.overflow, 0);
      check("wrap_unf", b.underflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
